// File: rtl/knn_core_k6_if.sv
// Bus bundle between the k-NN core and its register wrapper.
// The wrapper drives the sample, test point and start lines; the core returns the sorted results.
interface knn_core_k6_if;
    logic        KNN_START_CORE;
    logic [31:0] KNN_DATA_PT_CORE;
    logic [31:0] KNN_TEST_PT_CORE;
    logic        KNN_VALID_CORE;
    logic        KNN_SAMPLE_CORE;
    logic        KNN_VALID_OUT_CORE;
    logic [31:0] KN1_OUT_CORE;
    logic [31:0] KN2_OUT_CORE;
    logic [31:0] KN3_OUT_CORE;
    logic [31:0] KN4_OUT_CORE;
    logic [31:0] KN5_OUT_CORE;
    logic [31:0] KN6_OUT_CORE;
    logic [6:0]  IN1_OUT_CORE;
    logic [6:0]  IN2_OUT_CORE;
    logic [6:0]  IN3_OUT_CORE;
    logic [6:0]  IN4_OUT_CORE;
    logic [6:0]  IN5_OUT_CORE;
    logic [6:0]  IN6_OUT_CORE;

    modport master (
        output KNN_START_CORE, KNN_DATA_PT_CORE, KNN_TEST_PT_CORE, KNN_VALID_CORE, KNN_SAMPLE_CORE,
        input  KNN_VALID_OUT_CORE,
        input  KN1_OUT_CORE, KN2_OUT_CORE, KN3_OUT_CORE, KN4_OUT_CORE, KN5_OUT_CORE, KN6_OUT_CORE,
        input  IN1_OUT_CORE, IN2_OUT_CORE, IN3_OUT_CORE, IN4_OUT_CORE, IN5_OUT_CORE, IN6_OUT_CORE
    );

    modport slave (
        input  KNN_START_CORE, KNN_DATA_PT_CORE, KNN_TEST_PT_CORE, KNN_VALID_CORE, KNN_SAMPLE_CORE,
        output KNN_VALID_OUT_CORE,
        output KN1_OUT_CORE, KN2_OUT_CORE, KN3_OUT_CORE, KN4_OUT_CORE, KN5_OUT_CORE, KN6_OUT_CORE,
        output IN1_OUT_CORE, IN2_OUT_CORE, IN3_OUT_CORE, IN4_OUT_CORE, IN5_OUT_CORE, IN6_OUT_CORE
    );
endinterface

// File: rtl/knn_core_k6.sv
// K=6 nearest-neighbour search over up to 128 stored 2-D points.
// Three-stage scan pipeline: memory read, squared distance, sorted insertion.
module knn_core_k6 (
    input  logic          CLK_CORE,
    input  logic          RST_CORE,
    knn_core_k6_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        start_q;
    logic        start_edge_s, accept_s, wr_en_s;
    logic [31:0] mem_q [128];
    logic [6:0]  wp_q, wp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rd_idx_q, rd_idx_d;
    logic [31:0] test_q, test_d;
    logic        v1_q, v1_d;
    logic [31:0] rd_data_q;
    logic [6:0]  idx1_q;
    logic        v2_q;
    logic [31:0] dist_q;
    logic [6:0]  idx2_q;
    logic        valid_q, valid_d;
    logic [31:0] kn_q [6];
    logic [31:0] kn_d [6];
    logic [6:0]  in_q [6];
    logic [6:0]  in_d [6];
    logic [5:0]  lt_s;

    // Squared Euclidean distance at 35 bits, clamped to all-ones when it overflows 32 bits.
    function automatic logic [31:0] sq_dist(input logic [31:0] a, input logic [31:0] b);
        logic signed [16:0] dx;
        logic signed [16:0] dy;
        logic signed [34:0] sx;
        logic signed [34:0] sy;
        logic [34:0]        sum;
        dx  = {a[31], a[31:16]} - {b[31], b[31:16]};
        dy  = {a[15], a[15:0]} - {b[15], b[15:0]};
        sx  = dx * dx;
        sy  = dy * dy;
        sum = $unsigned(sx) + $unsigned(sy);
        return (sum[34:32] != 3'd0) ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign start_edge_s = bus.KNN_START_CORE & ~start_q;
    assign accept_s     = start_edge_s & (state_q != ST_SCAN);
    assign wr_en_s      = bus.KNN_VALID_CORE & bus.KNN_SAMPLE_CORE & (state_q != ST_SCAN);

    // Candidate beats slot p under strict less-than; slots are sorted so lt_s is monotone.
    always_comb begin
        for (int p = 0; p < 6; p++) begin
            lt_s[p] = (dist_q < kn_q[p]);
        end
    end

    // Next-state: control FSM, write pointer/count, and sorted-slot insertion.
    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        test_d   = test_q;
        valid_d  = valid_q;
        v1_d     = 1'b0;
        kn_d     = kn_q;
        in_d     = in_q;

        if (wr_en_s) begin
            wp_d  = wp_q + 7'd1;
            cnt_d = (cnt_q == 8'd128) ? cnt_q : cnt_q + 8'd1;
        end else begin
            wp_d  = wp_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d  = ST_SCAN;
                    rd_idx_d = 8'd0;
                    test_d   = bus.KNN_TEST_PT_CORE;
                    valid_d  = 1'b0;
                    for (int p = 0; p < 6; p++) begin
                        kn_d[p] = 32'hFFFF_FFFF;
                        in_d[p] = 7'd0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCAN: begin
                if (rd_idx_q < cnt_q) begin
                    v1_d     = 1'b1;
                    rd_idx_d = rd_idx_q + 8'd1;
                end else if (!v1_q && !v2_q) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    wp_d    = 7'd0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_SCAN;
                end
                // Insert at the first losing slot and shift the tail down; equal distances stay behind.
                if (v2_q) begin
                    if (lt_s[0]) begin
                        kn_d[0] = dist_q;
                        in_d[0] = idx2_q;
                    end else begin
                        kn_d[0] = kn_q[0];
                    end
                    for (int p = 1; p < 6; p++) begin
                        if (lt_s[p]) begin
                            kn_d[p] = lt_s[p-1] ? kn_q[p-1] : dist_q;
                            in_d[p] = lt_s[p-1] ? in_q[p-1] : idx2_q;
                        end else begin
                            kn_d[p] = kn_q[p];
                        end
                    end
                end else begin
                    kn_d = kn_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, pipeline-valid and result registers with synchronous reset.
    always_ff @(posedge CLK_CORE) begin
        if (RST_CORE) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            wp_q     <= 7'd0;
            cnt_q    <= 8'd0;
            rd_idx_q <= 8'd0;
            test_q   <= 32'd0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            idx1_q   <= 7'd0;
            idx2_q   <= 7'd0;
            dist_q   <= 32'd0;
            valid_q  <= 1'b0;
            for (int p = 0; p < 6; p++) begin
                kn_q[p] <= 32'hFFFF_FFFF;
                in_q[p] <= 7'd0;
            end
        end else begin
            state_q  <= state_d;
            start_q  <= bus.KNN_START_CORE;
            wp_q     <= wp_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
            test_q   <= test_d;
            v1_q     <= v1_d;
            v2_q     <= v1_q;
            idx1_q   <= rd_idx_q[6:0];
            idx2_q   <= idx1_q;
            dist_q   <= sq_dist(rd_data_q, test_q);
            valid_q  <= valid_d;
            kn_q     <= kn_d;
            in_q     <= in_d;
        end
    end

    // Point storage and its registered read port; contents survive reset.
    always_ff @(posedge CLK_CORE) begin
        if (wr_en_s) begin
            mem_q[wp_q] <= bus.KNN_DATA_PT_CORE;
        end
        rd_data_q <= mem_q[rd_idx_q[6:0]];
    end

    assign bus.KNN_VALID_OUT_CORE = valid_q;
    assign bus.KN1_OUT_CORE = kn_q[0];
    assign bus.KN2_OUT_CORE = kn_q[1];
    assign bus.KN3_OUT_CORE = kn_q[2];
    assign bus.KN4_OUT_CORE = kn_q[3];
    assign bus.KN5_OUT_CORE = kn_q[4];
    assign bus.KN6_OUT_CORE = kn_q[5];
    assign bus.IN1_OUT_CORE = in_q[0];
    assign bus.IN2_OUT_CORE = in_q[1];
    assign bus.IN3_OUT_CORE = in_q[2];
    assign bus.IN4_OUT_CORE = in_q[3];
    assign bus.IN5_OUT_CORE = in_q[4];
    assign bus.IN6_OUT_CORE = in_q[5];
endmodule

// File: tb/tb_knn_core_k6.sv
// Directed bench for knn_core_k6: load, scan timing, ordering, ties, wrap, start handling,
// saturation and reset mid-scan, with hand-computed expected values.
module tb_knn_core_k6;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    knn_core_k6_if bus ();

    knn_core_k6 dut (
        .CLK_CORE (clk),
        .RST_CORE (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] kn_obs [6];
    logic [6:0]  in_obs [6];
    assign kn_obs[0] = bus.KN1_OUT_CORE;
    assign kn_obs[1] = bus.KN2_OUT_CORE;
    assign kn_obs[2] = bus.KN3_OUT_CORE;
    assign kn_obs[3] = bus.KN4_OUT_CORE;
    assign kn_obs[4] = bus.KN5_OUT_CORE;
    assign kn_obs[5] = bus.KN6_OUT_CORE;
    assign in_obs[0] = bus.IN1_OUT_CORE;
    assign in_obs[1] = bus.IN2_OUT_CORE;
    assign in_obs[2] = bus.IN3_OUT_CORE;
    assign in_obs[3] = bus.IN4_OUT_CORE;
    assign in_obs[4] = bus.IN5_OUT_CORE;
    assign in_obs[5] = bus.IN6_OUT_CORE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic signed [15:0] x, input logic signed [15:0] y);
        bus.KNN_DATA_PT_CORE = {x, y};
        bus.KNN_VALID_CORE   = 1'b1;
        bus.KNN_SAMPLE_CORE  = 1'b1;
        tick();
        bus.KNN_VALID_CORE   = 1'b0;
        bus.KNN_SAMPLE_CORE  = 1'b0;
    endtask

    // Start pulse: the edge after this call is edge 0.
    task automatic start_pulse(input logic [31:0] tp);
        bus.KNN_TEST_PT_CORE = tp;
        bus.KNN_START_CORE   = 1'b1;
        tick();
        bus.KNN_START_CORE   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("%s_kn%0d", tag, p + 1), kn_obs[p], 32'hFFFF_FFFF);
            chk($sformatf("%s_in%0d", tag, p + 1), {25'd0, in_obs[p]}, 32'd0);
        end
    endtask

    logic [31:0] exp_kn [6];
    logic [6:0]  exp_in [6];
    int          bad;

    initial begin
        checks = 0;
        errors = 0;
        bus.KNN_START_CORE   = 1'b0;
        bus.KNN_DATA_PT_CORE = 32'd0;
        bus.KNN_TEST_PT_CORE = 32'd0;
        bus.KNN_VALID_CORE   = 1'b0;
        bus.KNN_SAMPLE_CORE  = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Ordered load: (k,0), k=0..7, test (0,0); valid at edge 11.
        for (int k = 0; k < 8; k++) wr(16'(k), 16'sd0);
        start_pulse(32'd0);
        ticks(10);
        chk("ord_valid_e10", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        tick();
        chk("ord_valid_e11", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        exp_kn = '{32'd0, 32'd1, 32'd4, 32'd9, 32'd16, 32'd25};
        exp_in = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("ord_kn%0d", p + 1), kn_obs[p], exp_kn[p]);
            chk($sformatf("ord_in%0d", p + 1), {25'd0, in_obs[p]}, {25'd0, exp_in[p]});
        end

        // A write in DONE keeps results; it also becomes index 0 of the next set.
        wr(-16'sd3, 16'sd0);
        chk("done_wr_valid", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("done_wr_kn2", bus.KN2_OUT_CORE, 32'd1);
        wr(16'sd3, 16'sd0);
        wr(16'sd0, 16'sd3);
        wr(16'sd2, 16'sd2);
        start_pulse(32'd0);
        chk("tie_valid_clr", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        ticks(7);
        chk("tie_valid", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        exp_kn = '{32'd8, 32'd9, 32'd9, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_in = '{7'd3, 7'd0, 7'd1, 7'd2, 7'd0, 7'd0};
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("tie_kn%0d", p + 1), kn_obs[p], exp_kn[p]);
            chk($sformatf("tie_in%0d", p + 1), {25'd0, in_obs[p]}, {25'd0, exp_in[p]});
        end

        // Wrap: 128 points (i,i) then (50,50) overwrites index 0; valid at edge 131.
        for (int i = 0; i < 128; i++) wr(16'(i), 16'(i));
        wr(16'sd50, 16'sd50);
        start_pulse({16'sd50, 16'sd50});
        ticks(130);
        chk("wrap_valid_e130", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        tick();
        chk("wrap_valid_e131", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("wrap_kn1", bus.KN1_OUT_CORE, 32'd0);
        chk("wrap_in1", {25'd0, bus.IN1_OUT_CORE}, 32'd0);
        chk("wrap_kn2", bus.KN2_OUT_CORE, 32'd0);
        chk("wrap_in2", {25'd0, bus.IN2_OUT_CORE}, 32'd50);
        chk("wrap_kn3", bus.KN3_OUT_CORE, 32'd2);
        chk("wrap_in3", {25'd0, bus.IN3_OUT_CORE}, 32'd49);

        // START held high 200 cycles: exactly one scan (cnt=2 -> valid at edge 5, then stays).
        wr(16'sd3, 16'sd4);
        wr(16'sd1, 16'sd1);
        bus.KNN_TEST_PT_CORE = 32'd0;
        bus.KNN_START_CORE   = 1'b1;
        tick();
        ticks(4);
        chk("hold_valid_e4", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        tick();
        chk("hold_valid_e5", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("hold_kn1", bus.KN1_OUT_CORE, 32'd2);
        chk("hold_in1", {25'd0, bus.IN1_OUT_CORE}, 32'd1);
        chk("hold_kn2", bus.KN2_OUT_CORE, 32'd25);
        chk("hold_in2", {25'd0, bus.IN2_OUT_CORE}, 32'd0);
        bad = 0;
        for (int i = 0; i < 195; i++) begin
            tick();
            if (bus.KNN_VALID_OUT_CORE !== 1'b1) bad++;
        end
        chk("hold_no_retrigger", 32'(bad), 32'd0);
        bus.KNN_START_CORE = 1'b0;
        tick();

        // Start edge during SCAN ignored: cnt=3 -> valid exactly at edge 6.
        wr(16'sd1, 16'sd0);
        wr(16'sd2, 16'sd0);
        wr(16'sd3, 16'sd0);
        start_pulse(32'd0);
        tick();
        bus.KNN_START_CORE = 1'b1;
        tick();
        bus.KNN_START_CORE = 1'b0;
        ticks(3);
        chk("scan_edge_valid_e5", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        tick();
        chk("scan_edge_valid_e6", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("scan_edge_kn1", bus.KN1_OUT_CORE, 32'd1);
        chk("scan_edge_kn3", bus.KN3_OUT_CORE, 32'd9);
        chk("scan_edge_in3", {25'd0, bus.IN3_OUT_CORE}, 32'd2);

        // Empty set: DONE one cycle after the start with initial slot values.
        start_pulse(32'd0);
        chk("empty_valid_e0", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        tick();
        chk("empty_valid_e1", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("empty_kn1", bus.KN1_OUT_CORE, 32'hFFFF_FFFF);
        chk("empty_in1", {25'd0, bus.IN1_OUT_CORE}, 32'd0);
        chk("empty_kn6", bus.KN6_OUT_CORE, 32'hFFFF_FFFF);

        // Saturation: (-32768,-32768) vs (32767,32767) exceeds 32 bits, so no insertion.
        wr(-16'sd32768, -16'sd32768);
        start_pulse({16'sd32767, 16'sd32767});
        ticks(4);
        chk("sat_valid", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd1);
        chk("sat_kn1", bus.KN1_OUT_CORE, 32'hFFFF_FFFF);
        chk("sat_in1", {25'd0, bus.IN1_OUT_CORE}, 32'd0);

        // Largest in-range case: (-32768,0) vs (32767,0) = 65535^2.
        wr(-16'sd32768, 16'sd0);
        start_pulse({16'sd32767, 16'sd0});
        ticks(4);
        chk("big_kn1", bus.KN1_OUT_CORE, 32'hFFFE_0001);

        // Reset mid-scan abandons the scan and restores reset values.
        for (int k = 0; k < 10; k++) wr(16'(k), 16'sd0);
        start_pulse(32'd0);
        ticks(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_mid");
        ticks(20);
        chk("rst_mid_stay_valid", {31'd0, bus.KNN_VALID_OUT_CORE}, 32'd0);
        chk("rst_mid_stay_kn1", bus.KN1_OUT_CORE, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_core_k6.md
# knn_core_k6

K-nearest-neighbour search engine (K = 6) for 2-D points. It captures up to 128 data points into internal storage. On a start request it scans every stored point against a test point and reports the six smallest squared Euclidean distances, with their storage indices, in ascending order. It sits behind a register/peripheral wrapper that streams samples in and reads back results.

## Interface
- No parameters: depth fixed at 128, K fixed at 6, coordinate width fixed at 16.
- CLK_CORE  in  1  single clock, rising edge.
- RST_CORE  in  1  reset, synchronous and active-high.
- KNN_START_CORE  in  1  start request; its rising edge is the trigger.
- KNN_DATA_PT_CORE  in  32  data point {x[31:16], y[15:0]}, each coordinate signed two's complement.
- KNN_TEST_PT_CORE  in  32  test point {x, y}, same format.
- KNN_VALID_CORE  in  1  data-point write strobe.
- KNN_SAMPLE_CORE  in  1  sample-add enable; a write occurs only when VALID and SAMPLE are both 1.
- KNN_VALID_OUT_CORE  out  1  results valid.
- KN1_OUT_CORE … KN6_OUT_CORE  out  32 each  sorted distances; KN1 is the smallest.
- IN1_OUT_CORE … IN6_OUT_CORE  out  7 each  storage index of the matching KNn.

## Operation
- Storage: 128 × 32-bit array, a 7-bit write pointer `wp` and an 8-bit count `cnt` (saturates at 128).
- Write:
  - Condition: VALID & SAMPLE in IDLE or DONE.
  - mem[wp] <= DATA_PT; wp <= wp+1, wrapping 127→0; cnt <= min(cnt+1, 128).
  - The 129th write overwrites index 0.
  - Writes during SCAN are ignored.
- Start detection:
  - start_edge = START & ~start_q, where start_q is START registered.
  - start_edge is accepted only in IDLE or DONE and ignored during SCAN.
  - Holding START high does not retrigger.
- Acceptance of a start:
  - Latches TEST_PT.
  - Clears VALID_OUT.
  - Initialises all six slots to distance 0xFFFFFFFF, index 0.
  - Moves to SCAN with read index 0.
- States:
  - IDLE → SCAN on start_edge.
  - SCAN issues read indices 0..cnt-1, one per cycle, then drains the pipeline → DONE.
  - DONE holds results. On entering DONE, wp and cnt are cleared, so the next write starts a new set at index 0.
  - DONE → SCAN on start_edge.
  - cnt = 0 at start: go to DONE the next cycle with the initial slot values.
- Distance:
  - dx = x_d − x_t and dy = y_d − y_t, each 17-bit signed.
  - d = dx² + dy², computed at 35 bits, then saturated to 0xFFFFFFFF if above 32 bits.
- Insertion, one candidate (d, idx) per cycle:
  - Find the first slot p with d < KNp, using strict less-than.
  - Slots p..5 shift down one position; KN6 is dropped.
  - (d, idx) is written into slot p.
  - Ties keep the earlier-stored point first.
- Outputs: KN*/IN* are the working slot registers. They are meaningful only while VALID_OUT = 1.

## Timing
- Reset (one cycle, RST_CORE=1):
  - State → IDLE; wp=0, cnt=0, start_q=0.
  - VALID_OUT=0, KN1–6=0xFFFFFFFF, IN1–6=0.
  - Memory contents are not reset.
- Reset mid-SCAN: same as above; the scan is abandoned.
- Writes take effect at the clock edge where the strobe is sampled; one write per cycle.
- Pipeline: stage 1 registered memory read, stage 2 distance register, stage 3 insert.
- Latency: with start_edge sampled at edge 0, VALID_OUT rises at edge cnt+3. For cnt=128 that is edge 131.
- VALID_OUT stays at 1 in DONE until the next accepted start or reset.
- A write in DONE does not clear VALID_OUT or the results.

## Test plan
- Reset: after RST_CORE=1 → VALID_OUT=0, KN1–6=0xFFFFFFFF, IN1–6=0.
- Ordered load and scan:
  - Stimulus: write 8 points (k,0) for k=0..7, test point (0,0), start pulse.
  - Required: at edge 11, VALID_OUT=1; KN1..KN6 = 0,1,4,9,16,25; IN1..IN6 = 0..5.
- Ties and signed coordinates:
  - Stimulus: points (−3,0), (3,0), (0,3), (2,2) at indices 0..3; test point (0,0).
  - Required: KN1=8/IN1=3; KN2..KN4 = 9 with IN = 0,1,2; KN5–6 = 0xFFFFFFFF.
- Wrap and overwrite:
  - Stimulus: 129 writes (index i = (i,i), the 129th = (50,50)); test point (50,50).
  - Required: KN1=0, IN1=0, VALID_OUT at edge 131.
- Start handling:
  - Stimulus: hold START high 200 cycles.
  - Required: exactly one scan; start_edge during SCAN is ignored; a start with cnt=0 gives all 0xFFFFFFFF one cycle later.
- Saturation and reset mid-scan:
  - Stimulus: data point (−32768,−32768) with test point (32767,32767); separately, RST_CORE asserted mid-scan.
  - Required: KN1=0xFFFFFFFF with IN1=0; reset mid-scan returns all outputs to reset values.
